io_in_fifo: RTL and testbench

IO_IN_FIFO -- requirements
Module: io_in_fifo

---
 rtl/io_in_fifo.sv | 87 ++++++++
 tb/tb_io_in_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/io_in_fifo.sv
// Per-port input FIFOs between an I/O producer and the processor read port.
// Each port owns a circular buffer; reads pop with a one-cycle registered latency.
module io_in_fifo #(
  parameter  int NUBITS = 16,
  parameter  int NBIOIN = 2,
  parameter  int FDEPTH = 4,
  localparam int NPORT  = 2**NBIOIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [NBIOIN-1:0] s_port,
  input  logic [NUBITS-1:0] s_data,
  output logic              s_ready,
  input  logic              req_in,
  input  logic [NBIOIN-1:0] addr_in,
  output logic [NUBITS-1:0] io_in,
  output logic [NPORT-1:0]  empty,
  output logic [NPORT-1:0]  full,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  logic [NUBITS-1:0] mem  [NPORT][FDEPTH];
  logic [AW-1:0]     rptr [NPORT];
  logic [AW-1:0]     wptr [NPORT];
  logic [CW-1:0]     cnt  [NPORT];

  logic             push;
  logic             pop;
  logic             uflow_evt;
  logic [NPORT-1:0] push_sel;
  logic [NPORT-1:0] pop_sel;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int p = 0; p < NPORT; p++) begin
      empty[p] = (cnt[p] == '0);
      full[p]  = (cnt[p] == CW'(FDEPTH));
    end
  end

  // A full port refuses the push even if it is being popped on the same edge.
  assign s_ready   = !full[s_port];
  assign push      = s_valid && s_ready;
  assign pop       = req_in && !empty[addr_in];
  assign uflow_evt = req_in && empty[addr_in];

  always_comb begin
    push_sel = '0;
    pop_sel  = '0;
    if (push) push_sel[s_port]  = 1'b1;
    if (pop)  pop_sel[addr_in]  = 1'b1;
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && rst) mem[s_port][wptr[s_port]] <= s_data;
  end

  // Read stage: pointers, counts, registered read data and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        rptr[p] <= '0;
        wptr[p] <= '0;
        cnt[p]  <= '0;
      end
      io_in     <= '0;
      underflow <= 1'b0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (push_sel[p]) wptr[p] <= wptr[p] + AW'(1);
        if (pop_sel[p])  rptr[p] <= rptr[p] + AW'(1);
        cnt[p] <= cnt[p] + CW'(push_sel[p]) - CW'(pop_sel[p]);
      end
      if (pop) io_in <= mem[addr_in][rptr[addr_in]];
      if (uflow_evt)    underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_in_fifo.sv
// Randomized and directed bench for io_in_fifo against a queue-per-port model.
module tb_io_in_fifo;

  localparam int NUBITS = 16;
  localparam int NBIOIN = 2;
  localparam int FDEPTH = 4;
  localparam int NPORT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic [NBIOIN-1:0] s_port = '0;
  logic [NUBITS-1:0] s_data = '0;
  logic              s_ready;
  logic              req_in = 1'b0;
  logic [NBIOIN-1:0] addr_in = '0;
  logic [NUBITS-1:0] io_in;
  logic [NPORT-1:0]  empty;
  logic [NPORT-1:0]  full;
  logic              underflow;
  logic              clr_err = 1'b0;

  io_in_fifo #(.NUBITS(NUBITS), .NBIOIN(NBIOIN), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_port(s_port), .s_data(s_data),
    .s_ready(s_ready), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .empty(empty), .full(full), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [NUBITS-1:0] q [NPORT][$];
  logic [NUBITS-1:0] exp_io = '0;
  logic              exp_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic chk_flags();
    logic [NPORT-1:0] e, f;
    for (int p = 0; p < NPORT; p++) begin
      e[p] = (q[p].size() == 0);
      f[p] = (q[p].size() == FDEPTH);
    end
    chk("empty", 32'(empty), 32'(e));
    chk("full", 32'(full), 32'(f));
  endtask

  // One clock of stimulus; the model applies the rules to its pre-edge state.
  task automatic cycle(input logic v, input logic [1:0] sp, input logic [15:0] sd,
                       input logic rq, input logic [1:0] ad, input logic ce);
    logic do_push, do_pop, uf_evt;
    s_valid = v; s_port = sp; s_data = sd;
    req_in = rq; addr_in = ad; clr_err = ce;
    #1;
    chk("s_ready", 32'(s_ready), 32'(q[sp].size() < FDEPTH));
    do_push = v && (q[sp].size() < FDEPTH);
    do_pop  = rq && (q[ad].size() > 0);
    uf_evt  = rq && (q[ad].size() == 0);
    if (do_pop) exp_io = q[ad].pop_front();
    if (do_push) q[sp].push_back(sd);
    if (uf_evt) exp_uf = 1'b1;
    else if (ce) exp_uf = 1'b0;
    @(posedge clk);
    #1;
    chk("io_in", 32'(io_in), 32'(exp_io));
    chk("underflow", 32'(underflow), 32'(exp_uf));
    chk_flags();
    s_valid = 1'b0; req_in = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push_w(input logic [1:0] p, input logic [15:0] d);
    cycle(1'b1, p, d, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic pop_w(input logic [1:0] p);
    cycle(1'b0, 2'd0, 16'h0, 1'b1, p, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_io", 32'(io_in), 32'h0);
    chk("rst_uf", 32'(underflow), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // basic push/pop on port 1
    push_w(2'd1, 16'h0011);
    push_w(2'd1, 16'h0022);
    pop_w(2'd1);
    chk("basic_rd0", 32'(io_in), 32'h0011);
    pop_w(2'd1);
    chk("basic_rd1", 32'(io_in), 32'h0022);
    chk("basic_empty1", 32'(empty[1]), 32'h1);

    // fill port 2, fifth push rejected
    for (int i = 0; i < 4; i++) push_w(2'd2, 16'h0201 + 16'(i));
    chk("full2", 32'(full[2]), 32'h1);
    push_w(2'd2, 16'h0205);
    for (int i = 0; i < 4; i++) begin
      pop_w(2'd2);
      chk("full_order", 32'(io_in), 32'(16'h0201 + 16'(i)));
    end

    // underflow on empty port 0, then clear
    pop_w(2'd0);
    chk("uf_hold", 32'(io_in), 32'h0204);
    chk("uf_set", 32'(underflow), 32'h1);
    cycle(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1);
    chk("uf_clr", 32'(underflow), 32'h0);
    // new underflow wins over clear on the same edge
    cycle(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b1);
    chk("uf_setwins", 32'(underflow), 32'h1);
    cycle(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1);

    // same-cycle push/pop on non-empty port 3
    push_w(2'd3, 16'h00AA);
    cycle(1'b1, 2'd3, 16'h00BB, 1'b1, 2'd3, 1'b0);
    chk("pp_io", 32'(io_in), 32'h00AA);
    chk("pp_cnt1", 32'({full[3], empty[3]}), 32'h0);
    pop_w(2'd3);
    chk("pp_next", 32'(io_in), 32'h00BB);

    // same-cycle push/pop on empty port 0: push stored, no bypass
    cycle(1'b1, 2'd0, 16'h0C0C, 1'b1, 2'd0, 1'b0);
    chk("pe_io", 32'(io_in), 32'h00BB);
    chk("pe_uf", 32'(underflow), 32'h1);
    pop_w(2'd0);
    chk("pe_rd", 32'(io_in), 32'h0C0C);
    cycle(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1);

    // pointer wrap on port 0
    for (int i = 0; i < 10; i++) begin
      push_w(2'd0, 16'h1000 + 16'(i));
      pop_w(2'd0);
      chk("wrap", 32'(io_in), 32'(16'h1000 + 16'(i)));
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-burst with port 1 holding two words
    for (int p = 0; p < NPORT; p++) begin
      while (q[p].size() > 0) pop_w(2'(p));
    end
    push_w(2'd3, 16'h5A5A);
    pop_w(2'd3);
    pop_w(2'd0);
    push_w(2'd1, 16'h0101);
    push_w(2'd1, 16'h0102);
    chk("pre_rst_uf", 32'(underflow), 32'h1);
    s_valid = 1'b1; s_port = 2'd1; s_data = 16'h0103;
    req_in = 1'b1; addr_in = 2'd1;
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'hF);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_io", 32'(io_in), 32'h0);
    chk("arst_uf", 32'(underflow), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_empty", 32'(empty), 32'hF);
    s_valid = 1'b0; req_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < NPORT; p++) q[p].delete();
    exp_io = '0;
    exp_uf = 1'b0;
    push_w(2'd1, 16'h0777);
    pop_w(2'd1);
    chk("post_rst_rd", 32'(io_in), 32'h0777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
